// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// uart_tx_mmio : memory-mapped 8N1 UART transmitter with a TX FIFO
// Rev 1.0
// ============================================================================
module uart_tx_mmio #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 234
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq_empty
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam int         CW       = PW + 1;
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic [15:0]   div_q;
  logic [15:0]   frame_div_q;
  logic [15:0]   bit_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          irq_q;

  logic w_full;
  logic w_empty;
  logic w_busy;
  logic w_push_req;
  logic w_push;
  logic w_pop;
  logic w_ovf_hit;
  logic w_stat_rd;
  logic w_div_wr;
  logic w_unused;

  assign w_full     = (count_q == CW'(FIFO_DEPTH));
  assign w_empty    = (count_q == '0);
  assign w_busy     = (state_q != S_IDLE);
  assign w_push_req = wen && (addr[3:2] == A_DATA);
  assign w_push     = w_push_req && !w_full;
  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_ovf_hit  = w_push_req && w_full;
  assign w_pop      = (state_q == S_IDLE) && !w_empty;
  assign w_stat_rd  = ren && (addr[3:2] == A_STATUS);
  assign w_div_wr   = wen && (addr[3:2] == A_DIV);
  assign count_d    = count_q + CW'(w_push) - CW'(w_pop);
  assign w_unused   = ^{addr[1:0], wdata[31:16]};

  assign tx        = tx_q;
  assign irq_empty = irq_q;

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      A_STATUS: begin
        rdata[0]       = w_full;
        rdata[1]       = w_empty;
        rdata[2]       = w_busy;
        rdata[3]       = ovf_q;
        rdata[4 +: CW] = count_q;
      end
      A_DIV:   rdata[15:0] = div_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= 16'(DEFAULT_DIV);
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      if (w_ovf_hit) begin
        ovf_q <= 1'b1;
      end else if (w_stat_rd) begin
        ovf_q <= 1'b0;
      end
      if (w_div_wr) begin
        div_q <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
    end
  end

  // Divisor is sampled into frame_div_q at frame start so DIV writes only affect later frames.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tx_q        <= 1'b1;
      irq_q       <= 1'b1;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_div_q <= 16'(DEFAULT_DIV);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_pop) begin
            shift_q     <= mem_q[rd_ptr_q];
            frame_div_q <= div_q;
            bit_cnt_q   <= div_q - 16'd1;
            tx_q        <= 1'b0;
            irq_q       <= 1'b0;
            state_q     <= S_START;
          end else begin
            irq_q <= (count_d == '0);
          end
        end
        S_START: begin
          if (bit_cnt_q == 16'd0) begin
            bit_cnt_q <= frame_div_q - 16'd1;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            state_q   <= S_DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_cnt_q == 16'd0) begin
            bit_cnt_q <= frame_div_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (bit_cnt_q == 16'd0) begin
            irq_q   <= (count_d == '0);
            state_q <= S_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_mmio : directed + random bench with a frame-timing reference model
// Rev 1.0
// ============================================================================
module tb_uart_tx_mmio;

  logic        clk;
  logic        resetn;
  logic [3:0]  addr;
  logic        ren;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq_empty;

  int total = 0;
  int bad   = 0;

  uart_tx_mmio #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(234)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .addr     (addr),
    .ren      (ren),
    .wen      (wen),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx       (tx),
    .irq_empty(irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the queue holds bytes not yet started; the active frame is described
  // by its start edge, end edge (back to idle), byte and bit period.
  logic [7:0] mq[$];
  int         t;
  int         m_div;
  int         m_fdiv;
  int         m_s;
  int         m_end;
  logic [7:0] m_fbyte;
  logic       m_ovf;

  task automatic m_reset();
    mq.delete();
    m_div   = 234;
    m_fdiv  = 1;
    m_s     = 0;
    m_end   = 0;
    m_fbyte = 8'h00;
    m_ovf   = 1'b0;
  endtask

  function automatic logic m_busy_at(int e);
    return (e >= m_s) && (e < m_end);
  endfunction

  function automatic logic m_tx(int e);
    int k;
    if (!m_busy_at(e)) return 1'b1;
    k = (e - m_s) / m_fdiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_fbyte[k-1];
    return 1'b1;
  endfunction

  function automatic logic m_irq();
    return !m_busy_at(t) && (mq.size() == 0);
  endfunction

  function automatic logic [31:0] m_read(logic [3:0] a);
    case (a[3:2])
      2'd1: return {23'd0, 5'(mq.size()), m_ovf, m_busy_at(t),
                    logic'(mq.size() == 0), logic'(mq.size() == 16)};
      2'd2: return {16'd0, 16'(m_div)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [3:0] a,
                            input logic [31:0] d, input logic r);
    int   n;
    logic ovf_hit;
    n       = mq.size();
    ovf_hit = 1'b0;
    t++;
    if (!m_busy_at(t - 1) && n > 0) begin
      m_fbyte = mq.pop_front();
      m_fdiv  = m_div;
      m_s     = t;
      m_end   = t + 10 * m_div;
    end
    if (w && a[3:2] == 2'd0) begin
      if (n == 16) ovf_hit = 1'b1;
      else mq.push_back(d[7:0]);
    end
    if (r && a[3:2] == 2'd1) m_ovf = 1'b0;
    if (ovf_hit) m_ovf = 1'b1;
    if (w && a[3:2] == 2'd2) m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h edge=%0d", tag, obs, exp, t);
    end
  endtask

  // Called at posedge+1: drive, check read data mid-cycle, clock, check outputs.
  task automatic step(input logic w, input logic [3:0] a, input logic [31:0] d, input logic r);
    wen   = w;
    addr  = a;
    wdata = d;
    ren   = r;
    #3;
    chk("rdata", rdata, m_read(a));
    @(posedge clk);
    model_edge(w, a, d, r);
    #1;
    chk("tx", {31'd0, tx}, {31'd0, m_tx(t)});
    chk("irq_empty", {31'd0, irq_empty}, {31'd0, m_irq()});
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'd0, 1'b0);
  endtask

  task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    ren  = 1'b0;
    wen  = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    int         r;
    logic [3:0] a;
    resetn = 1'b0;
    wen    = 1'b0;
    ren    = 1'b0;
    addr   = 4'h0;
    wdata  = 32'd0;
    t      = 0;
    m_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_irq", {31'd0, irq_empty}, 32'd1);
    resetn = 1'b1;
    peek(4'h4, 32'h0000_0002, "rst_status");
    peek(4'h8, 32'd234, "rst_div");
    idle(2);

    // DIV=4, single 0x55 frame
    step(1'b1, 4'h8, 32'd4, 1'b0);
    step(1'b1, 4'h0, 32'h55, 1'b0);
    idle(1);
    chk("tx_fall_n1", {31'd0, tx}, 32'd0);
    idle(39);
    chk("irq_low_n40", {31'd0, irq_empty}, 32'd0);
    idle(1);
    chk("irq_high_n41", {31'd0, irq_empty}, 32'd1);
    idle(3);

    // DIV=1, fill FIFO then overflow
    step(1'b1, 4'h8, 32'd1, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 4'h0, 32'(8'h10 + i), 1'b0);
    peek(4'h4, 32'h0000_010D, "ovf_status");
    step(1'b0, 4'h4, 32'd0, 1'b1);
    peek(4'h4, 32'h0000_0105, "ovf_cleared");
    idle(200);

    // DIV change mid-frame applies to the next frame only
    step(1'b1, 4'h8, 32'd8, 1'b0);
    step(1'b1, 4'h0, 32'hA3, 1'b0);
    idle(15);
    step(1'b1, 4'h8, 32'd2, 1'b0);
    step(1'b1, 4'h0, 32'h0F, 1'b0);
    idle(64);
    chk("gap_idle_clock", {31'd0, tx}, 32'd1);
    idle(1);
    chk("frame2_start", {31'd0, tx}, 32'd0);
    idle(30);

    // Asynchronous reset mid-frame with bytes queued
    step(1'b1, 4'h8, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, 32'(8'hC0 + i), 1'b0);
    chk("pre_rst_low", {31'd0, tx}, 32'd0);
    #1 resetn = 1'b0;
    #1 chk("async_rst_tx", {31'd0, tx}, 32'd1);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    peek(4'h4, 32'h0000_0002, "post_rst_status");
    idle(60);

    // DIV write of 0 stores 1
    step(1'b1, 4'h8, 32'd0, 1'b0);
    peek(4'h8, 32'd1, "div0_read");
    step(1'b1, 4'h0, 32'hFF, 1'b0);
    idle(15);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      a = {2'b00, 2'($urandom)};
      if (r < 30)      step(1'b1, a, $urandom, 1'b0);
      else if (r < 35) step(1'b1, a | 4'h8, {16'($urandom), 16'($urandom_range(0, 5))}, 1'b0);
      else if (r < 45) step(1'b0, a | 4'h4, $urandom, 1'b1);
      else if (r < 50) step(1'($urandom), a | 4'hC, $urandom, 1'($urandom));
      else             step(1'b0, 4'($urandom), $urandom, 1'b0);
    end
    idle(900);
    peek(4'h4, 32'h0000_0002, "final_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
